// File: rtl/parking_exit_gate_pkg.sv
// ----------------------------------------------------------------------
// parking_exit_gate_pkg : exit-gate state codes, exit code and glyphs
// Rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

package parking_exit_gate_pkg;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_WAIT_CODE  = 3'd1;
  localparam logic [2:0] ST_WRONG_CODE = 3'd2;
  localparam logic [2:0] ST_OPEN       = 3'd3;
  localparam logic [2:0] ST_BLOCKED    = 3'd4;

  localparam logic [1:0] EXIT_CODE_1 = 2'b10;
  localparam logic [1:0] EXIT_CODE_2 = 2'b01;

  typedef logic [6:0] seg_t;

  // Active-low segment patterns, shared with the entrance controller.
  typedef struct packed {
    seg_t hex_1;
    seg_t hex_2;
  } glyph_pair_t;

  localparam glyph_pair_t GLYPH_BLANK = {7'b1111111, 7'b1111111};
  localparam glyph_pair_t GLYPH_EN    = {7'b0000110, 7'b0101011};
  localparam glyph_pair_t GLYPH_EE    = {7'b0000110, 7'b0000110};
  localparam glyph_pair_t GLYPH_GO    = {7'b0000010, 7'b1000000};
  localparam glyph_pair_t GLYPH_SP    = {7'b0010010, 7'b0001100};

  function automatic logic exit_code_valid(input logic [1:0] c1, input logic [1:0] c2);
    return (c1 == EXIT_CODE_1) && (c2 == EXIT_CODE_2);
  endfunction

endpackage

`default_nettype wire

// File: rtl/parking_exit_gate_occupancy_counter.sv
// ----------------------------------------------------------------------
// occupancy_counter : saturating car count with registered full/empty
// Rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

module occupancy_counter #(
  parameter int CAPACITY = 8,
  parameter int OCC_W    = $clog2(CAPACITY + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             dec,
  output logic [OCC_W-1:0] occupancy,
  output logic             lot_full,
  output logic             lot_empty
);

  localparam logic [OCC_W-1:0] CAP_VAL = OCC_W'(CAPACITY);

  logic [OCC_W-1:0] occ_next;

  always_comb begin
    occ_next = occupancy;
    if (inc && !dec) begin
      if (occupancy != CAP_VAL) occ_next = occupancy + OCC_W'(1);
    end else if (dec && !inc) begin
      if (occupancy != '0) occ_next = occupancy - OCC_W'(1);
    end
  end

  // Flags are taken from the next value so they line up with occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occupancy <= '0;
      lot_full  <= 1'b0;
      lot_empty <= 1'b1;
    end else begin
      occupancy <= occ_next;
      lot_full  <= (occ_next == CAP_VAL);
      lot_empty <= (occ_next == '0);
    end
  end

endmodule

`default_nettype wire

// File: rtl/parking_exit_gate.sv
// ----------------------------------------------------------------------
// parking_exit_gate : exit barrier FSM with code check, timers and display
// Rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

module parking_exit_gate
  import parking_exit_gate_pkg::*;
#(
  parameter int CAPACITY      = 8,
  parameter int CODE_WAIT     = 4,
  parameter int CLEAR_TIMEOUT = 15
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            sensor_exit_in,
  input  logic                            sensor_exit_out,
  input  logic                            entry_admit,
  input  logic [1:0]                      code_1,
  input  logic [1:0]                      code_2,
  output logic                            GREEN_LED,
  output logic                            RED_LED,
  output logic [6:0]                      HEX_1,
  output logic [6:0]                      HEX_2,
  output logic [$clog2(CAPACITY+1)-1:0]   occupancy,
  output logic                            lot_full,
  output logic                            lot_empty
);

  localparam int WAIT_W = (CODE_WAIT > 0) ? $clog2(CODE_WAIT + 1) : 1;
  localparam int CLR_W  = (CLEAR_TIMEOUT > 0) ? $clog2(CLEAR_TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(CODE_WAIT);
  localparam logic [CLR_W-1:0]  CLR_LAST  = CLR_W'(CLEAR_TIMEOUT);

  logic [2:0]        state;
  logic [2:0]        next_state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [CLR_W-1:0]  clr_cnt;
  logic              code_ok;
  logic              car_left;

  assign code_ok  = exit_code_valid(code_1, code_2);
  assign car_left = (state == ST_OPEN) && sensor_exit_out;

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        // A car at the barrier with an empty lot is a phantom and is ignored.
        if (sensor_exit_in && (occupancy != '0)) next_state = ST_WAIT_CODE;
      end
      ST_WAIT_CODE: begin
        if (wait_cnt == WAIT_LAST) next_state = code_ok ? ST_OPEN : ST_WRONG_CODE;
      end
      ST_WRONG_CODE: begin
        if (code_ok) next_state = ST_OPEN;
      end
      ST_OPEN: begin
        if (sensor_exit_in && sensor_exit_out) next_state = ST_BLOCKED;
        else if (sensor_exit_out)              next_state = ST_IDLE;
        else if (clr_cnt == CLR_LAST)          next_state = ST_BLOCKED;
      end
      ST_BLOCKED: begin
        if (code_ok) next_state = ST_OPEN;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Timers run only while the state is held; any entry restarts them at zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      clr_cnt  <= '0;
    end else begin
      state <= next_state;
      if (state == ST_WAIT_CODE && next_state == ST_WAIT_CODE) wait_cnt <= wait_cnt + WAIT_W'(1);
      else                                                       wait_cnt <= '0;
      if (state == ST_OPEN && next_state == ST_OPEN) clr_cnt <= clr_cnt + CLR_W'(1);
      else                                           clr_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      GREEN_LED <= 1'b0;
      RED_LED   <= 1'b0;
      HEX_1     <= GLYPH_BLANK.hex_1;
      HEX_2     <= GLYPH_BLANK.hex_2;
    end else begin
      case (state)
        ST_WAIT_CODE: begin
          GREEN_LED <= 1'b0;
          RED_LED   <= 1'b1;
          HEX_1     <= GLYPH_EN.hex_1;
          HEX_2     <= GLYPH_EN.hex_2;
        end
        ST_WRONG_CODE: begin
          GREEN_LED <= 1'b0;
          RED_LED   <= ~RED_LED;
          HEX_1     <= GLYPH_EE.hex_1;
          HEX_2     <= GLYPH_EE.hex_2;
        end
        ST_OPEN: begin
          GREEN_LED <= ~GREEN_LED;
          RED_LED   <= 1'b0;
          HEX_1     <= GLYPH_GO.hex_1;
          HEX_2     <= GLYPH_GO.hex_2;
        end
        ST_BLOCKED: begin
          GREEN_LED <= 1'b0;
          RED_LED   <= ~RED_LED;
          HEX_1     <= GLYPH_SP.hex_1;
          HEX_2     <= GLYPH_SP.hex_2;
        end
        default: begin
          GREEN_LED <= 1'b0;
          RED_LED   <= 1'b0;
          HEX_1     <= GLYPH_BLANK.hex_1;
          HEX_2     <= GLYPH_BLANK.hex_2;
        end
      endcase
    end
  end

  occupancy_counter #(
    .CAPACITY (CAPACITY),
    .OCC_W    ($clog2(CAPACITY + 1))
  ) u_occupancy (
    .clk       (clk),
    .reset_n   (reset_n),
    .inc       (entry_admit),
    .dec       (car_left),
    .occupancy (occupancy),
    .lot_full  (lot_full),
    .lot_empty (lot_empty)
  );

endmodule

`default_nettype wire

// File: tb/tb_parking_exit_gate.sv
// ----------------------------------------------------------------------
// tb_parking_exit_gate : vector table plus directed corner sequences
// Rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

module tb_parking_exit_gate;
  import parking_exit_gate_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       sensor_exit_in, sensor_exit_out, entry_admit;
  logic [1:0] code_1, code_2;
  logic       GREEN_LED, RED_LED;
  logic [6:0] HEX_1, HEX_2;
  logic [3:0] occupancy;
  logic       lot_full, lot_empty;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  parking_exit_gate #(.CAPACITY(8), .CODE_WAIT(4), .CLEAR_TIMEOUT(15)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .sensor_exit_in  (sensor_exit_in),
    .sensor_exit_out (sensor_exit_out),
    .entry_admit     (entry_admit),
    .code_1          (code_1),
    .code_2          (code_2),
    .GREEN_LED       (GREEN_LED),
    .RED_LED         (RED_LED),
    .HEX_1           (HEX_1),
    .HEX_2           (HEX_2),
    .occupancy       (occupancy),
    .lot_full        (lot_full),
    .lot_empty       (lot_empty)
  );

  typedef struct {
    logic       si, so, ad;
    logic [1:0] c1, c2;
    logic [2:0] st;
    int         occ;
    logic       red, green;
    logic [6:0] h1, h2;
  } vec_t;

  vec_t vecs[27];

  function automatic vec_t v(input logic si, input logic so, input logic ad, input logic ok,
                             input logic [2:0] st, input int occ, input logic red,
                             input logic green, input logic [13:0] hex);
    vec_t r;
    r.si = si; r.so = so; r.ad = ad;
    r.c1 = ok ? 2'b10 : 2'b00;
    r.c2 = ok ? 2'b01 : 2'b00;
    r.st = st; r.occ = occ; r.red = red; r.green = green;
    r.h1 = hex[13:7]; r.h2 = hex[6:0];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic si, input logic so, input logic ad, input logic ok);
    sensor_exit_in  = si;
    sensor_exit_out = so;
    entry_admit     = ad;
    code_1          = ok ? 2'b10 : 2'b00;
    code_2          = ok ? 2'b01 : 2'b00;
  endtask

  task automatic wait_state(input logic [2:0] s, input int lim);
    int n = 0;
    while (dut.state !== s && n < lim) begin
      step();
      n++;
    end
    chk("wait_state", 32'(dut.state), 32'(s));
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_state"}, 32'(dut.state), 32'(ST_IDLE));
    chk({tag, "_occ"}, 32'(occupancy), 32'd0);
    chk({tag, "_hex1"}, 32'(HEX_1), 32'h7f);
    chk({tag, "_hex2"}, 32'(HEX_2), 32'h7f);
    chk({tag, "_red"}, 32'(RED_LED), 32'd0);
    chk({tag, "_green"}, 32'(GREEN_LED), 32'd0);
    chk({tag, "_empty"}, 32'(lot_empty), 32'd1);
    chk({tag, "_full"}, 32'(lot_full), 32'd0);
  endtask

  initial begin
    logic [13:0] bl, en, ee, go, sp;
    bl = {7'b1111111, 7'b1111111};
    en = {7'b0000110, 7'b0101011};
    ee = {7'b0000110, 7'b0000110};
    go = {7'b0000010, 7'b1000000};
    sp = {7'b0010010, 7'b0001100};

    //           si so ad ok  state          occ red grn hex
    vecs[0]  = v(0, 0, 1, 0, ST_IDLE,       1, 0, 0, bl);
    vecs[1]  = v(0, 0, 1, 0, ST_IDLE,       2, 0, 0, bl);
    vecs[2]  = v(1, 0, 0, 1, ST_WAIT_CODE,  2, 0, 0, bl);
    vecs[3]  = v(1, 0, 0, 1, ST_WAIT_CODE,  2, 1, 0, en);
    vecs[4]  = v(1, 0, 0, 1, ST_WAIT_CODE,  2, 1, 0, en);
    vecs[5]  = v(1, 0, 0, 1, ST_WAIT_CODE,  2, 1, 0, en);
    vecs[6]  = v(1, 0, 0, 1, ST_WAIT_CODE,  2, 1, 0, en);
    vecs[7]  = v(1, 0, 0, 1, ST_OPEN,       2, 1, 0, en);
    vecs[8]  = v(0, 0, 0, 1, ST_OPEN,       2, 0, 1, go);
    vecs[9]  = v(0, 0, 0, 1, ST_OPEN,       2, 0, 0, go);
    vecs[10] = v(0, 1, 0, 1, ST_IDLE,       1, 0, 1, go);
    vecs[11] = v(0, 0, 0, 0, ST_IDLE,       1, 0, 0, bl);
    vecs[12] = v(1, 0, 0, 0, ST_WAIT_CODE,  1, 0, 0, bl);
    vecs[13] = v(1, 0, 0, 0, ST_WAIT_CODE,  1, 1, 0, en);
    vecs[14] = v(1, 0, 0, 0, ST_WAIT_CODE,  1, 1, 0, en);
    vecs[15] = v(1, 0, 0, 0, ST_WAIT_CODE,  1, 1, 0, en);
    vecs[16] = v(1, 0, 0, 0, ST_WAIT_CODE,  1, 1, 0, en);
    vecs[17] = v(1, 0, 0, 0, ST_WRONG_CODE, 1, 1, 0, en);
    vecs[18] = v(0, 0, 0, 0, ST_WRONG_CODE, 1, 0, 0, ee);
    vecs[19] = v(0, 0, 0, 0, ST_WRONG_CODE, 1, 1, 0, ee);
    vecs[20] = v(0, 0, 0, 1, ST_OPEN,       1, 0, 0, ee);
    vecs[21] = v(1, 1, 0, 0, ST_BLOCKED,    0, 0, 1, go);
    vecs[22] = v(0, 0, 0, 0, ST_BLOCKED,    0, 1, 0, sp);
    vecs[23] = v(0, 0, 0, 1, ST_OPEN,       0, 0, 0, sp);
    vecs[24] = v(0, 1, 0, 0, ST_IDLE,       0, 0, 1, go);
    vecs[25] = v(1, 0, 0, 0, ST_IDLE,       0, 0, 0, bl);
    vecs[26] = v(1, 0, 0, 0, ST_IDLE,       0, 0, 0, bl);

    set_in(0, 0, 0, 0);
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1 chk_idle_outputs("reset");
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 27; i++) begin
      set_in(vecs[i].si, vecs[i].so, vecs[i].ad, vecs[i].c1 == 2'b10);
      step();
      chk($sformatf("row%0d_state", i), 32'(dut.state), 32'(vecs[i].st));
      chk($sformatf("row%0d_occ", i), 32'(occupancy), 32'(vecs[i].occ));
      chk($sformatf("row%0d_full", i), 32'(lot_full), 32'(vecs[i].occ == 8));
      chk($sformatf("row%0d_empty", i), 32'(lot_empty), 32'(vecs[i].occ == 0));
      chk($sformatf("row%0d_red", i), 32'(RED_LED), 32'(vecs[i].red));
      chk($sformatf("row%0d_green", i), 32'(GREEN_LED), 32'(vecs[i].green));
      chk($sformatf("row%0d_hex1", i), 32'(HEX_1), 32'(vecs[i].h1));
      chk($sformatf("row%0d_hex2", i), 32'(HEX_2), 32'(vecs[i].h2));
    end

    // Clear timeout: 16 OPEN cycles without the car leaving -> BLOCKED.
    set_in(0, 0, 1, 0);
    repeat (3) step();
    chk("to_occ3", 32'(occupancy), 32'd3);
    set_in(1, 0, 0, 1);
    step();
    wait_state(ST_OPEN, 20);
    set_in(0, 0, 0, 0);
    repeat (15) step();
    chk("to_open_at15", 32'(dut.state), 32'(ST_OPEN));
    step();
    chk("to_blocked", 32'(dut.state), 32'(ST_BLOCKED));
    chk("to_occ_kept", 32'(occupancy), 32'd3);
    step();
    chk("to_hex1_sp", 32'(HEX_1), 32'(7'b0010010));
    chk("to_hex2_sp", 32'(HEX_2), 32'(7'b0001100));
    set_in(0, 0, 0, 1);
    step();
    chk("to_reopen", 32'(dut.state), 32'(ST_OPEN));

    // Admit and exit in the same cycle leave the count unchanged.
    set_in(0, 1, 1, 0);
    step();
    chk("same_state", 32'(dut.state), 32'(ST_IDLE));
    chk("same_occ", 32'(occupancy), 32'd3);

    // Reset in the middle of an OPEN transaction acts without a clock edge.
    set_in(1, 0, 0, 1);
    step();
    wait_state(ST_OPEN, 20);
    set_in(0, 0, 0, 0);
    step();
    chk("mid_hex1_go", 32'(HEX_1), 32'(7'b0000010));
    #2 reset_n = 1'b0;
    #1 chk_idle_outputs("midreset");
    @(negedge clk);
    reset_n = 1'b1;

    // Saturation at CAPACITY.
    set_in(0, 0, 1, 0);
    repeat (8) step();
    chk("sat8_occ", 32'(occupancy), 32'd8);
    chk("sat8_full", 32'(lot_full), 32'd1);
    step();
    chk("sat9_occ", 32'(occupancy), 32'd8);
    chk("sat9_full", 32'(lot_full), 32'd1);
    chk("sat9_empty", 32'(lot_empty), 32'd0);
    set_in(0, 0, 0, 0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
